// File: rtl/instr_fetch_if.sv
// Instruction fetch bus: memory request/response, instruction handoff to the
// core, and redirect/PC information from the datapath.
// Optional macro FETCH_MISALIGN_CHK_EN adds the sticky misalign_err signal.
interface instr_fetch_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] instr;
  logic            instr_valid;
  logic            instr_ack;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
`ifdef FETCH_MISALIGN_CHK_EN
  logic            misalign_err;
`endif

  // Fetch unit side
`ifdef FETCH_MISALIGN_CHK_EN
  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, misalign_err,
    input  imem_ready, imem_rdata, instr_ack, redirect, redirect_pc
  );
`else
  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc, pc_plus4,
    input  imem_ready, imem_rdata, instr_ack, redirect, redirect_pc
  );
`endif

  // Memory + core side
`ifdef FETCH_MISALIGN_CHK_EN
  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, misalign_err,
    output imem_ready, imem_rdata, instr_ack, redirect, redirect_pc
  );
`else
  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus4,
    output imem_ready, imem_rdata, instr_ack, redirect, redirect_pc
  );
`endif

endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the architectural PC and fetches one instruction per
// retire from a req/ready instruction memory. The fetched word is held in an
// instruction register until the core acks it; the next PC is pc+4 or the
// datapath redirect target.
// Optional feature macro: FETCH_MISALIGN_CHK_EN. When defined, an acked
// redirect to a non-word-aligned target sets a sticky misalign_err, leaves pc
// unchanged and parks the FSM in HALT until reset. When undefined, the low two
// bits of the redirect target are silently cleared.
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  instr_fetch_if.master bus
);

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;
  localparam logic [XLEN-1:0] WORD_MASK = 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_CHK_EN
  typedef enum logic [1:0] {
    S_REQ  = 2'b00,
    S_HOLD = 2'b01,
    S_HALT = 2'b10
  } state_t;
`else
  typedef enum logic [1:0] {
    S_REQ  = 2'b00,
    S_HOLD = 2'b01
  } state_t;
`endif

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;
  logic            vld_q;
  logic [XLEN-1:0] pc_nxt;
  logic            capture;
  logic            retire;
`ifdef FETCH_MISALIGN_CHK_EN
  logic            err_q;
  logic            set_err;
`endif

  // State register; reset may hit mid-request and simply abandons the fetch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath control: capture on memory ready, retire on ack
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    retire    = 1'b0;
    pc_nxt    = pc_q + PC_STEP;
`ifdef FETCH_MISALIGN_CHK_EN
    set_err   = 1'b0;
`endif
    case (state)
      S_REQ: begin
        if (bus.imem_ready) begin
          capture   = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.instr_ack) begin
          retire    = 1'b1;
          state_nxt = S_REQ;
          if (bus.redirect) begin
`ifdef FETCH_MISALIGN_CHK_EN
            if (bus.redirect_pc[1:0] != 2'b00) begin
              set_err   = 1'b1;
              pc_nxt    = pc_q;
              state_nxt = S_HALT;
            end else begin
              pc_nxt = bus.redirect_pc;
            end
`else
            pc_nxt = bus.redirect_pc & WORD_MASK;
`endif
          end
        end
      end
`ifdef FETCH_MISALIGN_CHK_EN
      S_HALT: begin
        state_nxt = S_HALT;
      end
`endif
      default: begin
        state_nxt = S_REQ;
      end
    endcase
  end

  // PC, instruction register and valid flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      vld_q   <= 1'b0;
    end else begin
      if (capture) begin
        instr_q <= bus.imem_rdata;
        vld_q   <= 1'b1;
      end
      if (retire) begin
        vld_q <= 1'b0;
        pc_q  <= pc_nxt;
      end
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  // Sticky misaligned-redirect flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (set_err) begin
      err_q <= 1'b1;
    end
  end

  assign bus.misalign_err = err_q;
`endif

  // Request is masked during reset so nothing is fetched until rst drops
  assign bus.imem_req    = (state == S_REQ) && !rst;
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = vld_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_q + PC_STEP;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios plus a randomized phase,
// all checked against a transaction-level model of the fetch rules.
module tb_instr_fetch_unit;

  logic clk;
  logic rst;

  instr_fetch_if bus ();
  instr_fetch_if bus2 ();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk),
    .rst(rst),
    .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_valid;
  logic        m_halt;
  logic        m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h0010_8113;
      32'h0000_0080: return 32'h0000_0000;
      default:       return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
    endcase
  endfunction

  task automatic check_outputs();
    chk("imem_req", {31'd0, bus.imem_req}, {31'd0, !m_valid && !m_halt});
    if (!m_valid && !m_halt) chk("imem_addr", bus.imem_addr, m_pc);
    chk("instr_valid", {31'd0, bus.instr_valid}, {31'd0, m_valid});
    chk("pc", bus.pc, m_pc);
    chk("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
    if (m_valid) chk("instr", bus.instr, m_instr);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("misalign_err", {31'd0, bus.misalign_err}, {31'd0, m_err});
`endif
  endtask

  // One clock cycle: drive inputs, check current outputs, advance the model
  task automatic tick(input logic rdy, input logic ack, input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    bus.imem_ready  = rdy;
    bus.instr_ack   = ack;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.imem_rdata  = bus.imem_req ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF;
    #1;
    check_outputs();
    if (m_halt) begin
      // parked until reset
    end else if (!m_valid) begin
      if (rdy) begin
        m_valid = 1'b1;
        m_instr = mem_word(m_pc);
      end
    end else if (ack) begin
      m_valid = 1'b0;
      if (!rd) begin
        m_pc = m_pc + 32'd4;
      end else begin
`ifdef FETCH_MISALIGN_CHK_EN
        if (rpc[1:0] != 2'b00) begin
          m_halt = 1'b1;
          m_err  = 1'b1;
        end else begin
          m_pc = rpc;
        end
`else
        m_pc = {rpc[31:2], 2'b00};
`endif
      end
    end
  endtask

  // Asynchronous reset asserted between edges, with a stray ready during reset
  task automatic do_reset(input int n);
    @(negedge clk);
    #2;
    rst = 1'b1;
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'hBAD0_0BAD;
    bus.instr_ack  = 1'b1;
    #1;
    m_pc = 32'h0; m_instr = 32'h13; m_valid = 1'b0; m_halt = 1'b0; m_err = 1'b0;
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_pc_plus4", bus.pc_plus4, 32'h4);
    chk("rst_instr", bus.instr, 32'h0000_0013);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("rst_err", {31'd0, bus.misalign_err}, 32'd0);
`endif
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      chk("rst_hold_req", {31'd0, bus.imem_req}, 32'd0);
      chk("rst_hold_valid", {31'd0, bus.instr_valid}, 32'd0);
    end
    bus.imem_ready = 1'b0;
    bus.instr_ack  = 1'b0;
    rst = 1'b0;
    #1;
    chk("rel_req", {31'd0, bus.imem_req}, 32'd1);
    chk("rel_addr", bus.imem_addr, 32'h0);
  endtask

  initial begin
    rst = 1'b0;
    bus.imem_ready = 1'b0; bus.imem_rdata = 32'h0; bus.instr_ack = 1'b0;
    bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
    bus2.imem_ready = 1'b0; bus2.imem_rdata = 32'h0; bus2.instr_ack = 1'b0;
    bus2.redirect = 1'b0; bus2.redirect_pc = 32'h0;

    // T1 reset
    do_reset(3);

    // T2 sequential zero-wait fetch
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    chk("opcode", {25'd0, bus.instr[6:0]}, 32'h13);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    chk("opcode2", {25'd0, bus.instr[6:0]}, 32'h13);

    // T3 three wait states at pc 8
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 32'h200);
    tick(1'b1, 1'b0, 1'b0, 32'h0);

    // T4 redirect: ignored without ack, taken with ack
    tick(1'b0, 1'b0, 1'b1, 32'h100);
    tick(1'b0, 1'b1, 1'b1, 32'h40);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    chk("redir_addr", bus.imem_addr, 32'h40);
    chk("redir_plus4", bus.pc_plus4, 32'h44);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    // self-loop refetch
    tick(1'b0, 1'b1, 1'b1, 32'h40);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    chk("selfloop_pc", bus.pc, 32'h40);
    // zero word at 0x80 passes through
    tick(1'b0, 1'b1, 1'b1, 32'h80);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    chk("zero_word", bus.instr, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 32'h0);

    // Randomized traffic, aligned targets only
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rpc;
      case ($urandom_range(0, 3))
        0: rpc = m_pc;
        1: rpc = 32'hFFFF_FFFC;
        default: rpc = $urandom & 32'hFFFF_FFFC;
      endcase
      tick($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0, rpc);
    end

    // T6 reset while waiting on memory, late ready ignored
    do_reset(1);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    do_reset(2);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    chk("refetch_instr", bus.instr, 32'h0050_0093);

    // Misaligned redirect to 0x42
    tick(1'b0, 1'b1, 1'b1, 32'h42);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("misalign_flag", {31'd0, bus.misalign_err}, 32'd1);
    chk("misalign_req", {31'd0, bus.imem_req}, 32'd0);
`else
    chk("misalign_pc", bus.pc, 32'h40);
`endif

    // T5 wrap on the second instance, idle in REQ at 0xFFFFFFFC since reset
    @(negedge clk);
    bus2.imem_ready = 1'b1;
    bus2.imem_rdata = 32'h0000_0013;
    #1;
    chk("wrap_req", {31'd0, bus2.imem_req}, 32'd1);
    chk("wrap_addr0", bus2.imem_addr, 32'hFFFF_FFFC);
    chk("wrap_plus4", bus2.pc_plus4, 32'h0);
    @(negedge clk);
    bus2.imem_ready = 1'b0;
    bus2.instr_ack  = 1'b1;
    bus2.redirect   = 1'b0;
    #1;
    chk("wrap_valid", {31'd0, bus2.instr_valid}, 32'd1);
    chk("wrap_pc", bus2.pc, 32'hFFFF_FFFC);
    chk("wrap_instr", bus2.instr, 32'h0000_0013);
    @(negedge clk);
    bus2.instr_ack = 1'b0;
    #1;
    chk("wrap_req2", {31'd0, bus2.imem_req}, 32'd1);
    chk("wrap_addr1", bus2.imem_addr, 32'h0);
    chk("wrap_plus4_1", bus2.pc_plus4, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
